// File: rtl/flex_updown_counter.sv
// Up/down counter with programmable upper bound R, wrap or saturate at the
// ends of the sequence, and a registered wrap pulse plus saturating wrap tally.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int NUM_WRAP_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     sat_mode,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     terminal_flag,
  output logic                     wrap_pulse,
  output logic [NUM_WRAP_BITS-1:0] wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] cnt_step;
  logic                    wrap;

  // A count above R (after a load or an R change) is treated as terminal
  // on an up step, so the >= comparison covers it.
  always_comb begin
    rollover_flag = (count_out == rollover_val);
    terminal_flag = count_down ? (count_out <= ONE) : (count_out >= rollover_val);
  end

  always_comb begin
    cnt_step = count_out;
    if (terminal_flag) begin
      if (!sat_mode) cnt_step = count_down ? rollover_val : ONE;
    end else begin
      cnt_step = count_down ? (count_out - ONE) : (count_out + ONE);
    end
  end

  assign wrap = count_enable & terminal_flag & ~sat_mode & ~clear & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else if (clear) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else if (load) begin
      count_out  <= load_val;
      wrap_pulse <= 1'b0;
    end else begin
      if (count_enable) count_out <= cnt_step;
      wrap_pulse <= wrap;
      // Tally sticks at all-ones; the pulse still fires on every wrap.
      if (wrap && (wrap_count != '1)) wrap_count <= wrap_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter: default instance plus a 2-bit
// wrap-tally instance sharing the same stimulus.
module tb_flex_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, clear, load, count_enable, count_down, sat_mode;
  logic [3:0] load_val, rollover_val;

  logic [3:0] count_out,  count_out2;
  logic       rollover_flag, terminal_flag, wrap_pulse;
  logic       rollover_flag2, terminal_flag2, wrap_pulse2;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count2;

  int n_cmp = 0;
  int n_err = 0;
  int pulses, pulses2;

  always #5 clk = ~clk;

  flex_updown_counter #(.NUM_CNT_BITS(4), .NUM_WRAP_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .sat_mode(sat_mode),
    .rollover_val(rollover_val), .count_out(count_out), .rollover_flag(rollover_flag),
    .terminal_flag(terminal_flag), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  flex_updown_counter #(.NUM_CNT_BITS(4), .NUM_WRAP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .sat_mode(sat_mode),
    .rollover_val(rollover_val), .count_out(count_out2), .rollover_flag(rollover_flag2),
    .terminal_flag(terminal_flag2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0; count_enable = 1'b0;
    step();
    clear = 1'b0;
  endtask

  int exp_up[12]  = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
  int exp_dn[5]   = '{2, 1, 4, 3, 2};

  initial begin
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    count_enable = 1'b0; count_down = 1'b0; sat_mode = 1'b0; rollover_val = 4'd0;
    #3;
    chk("rst_count", count_out, 0);
    chk("rst_wrap_count", wrap_count, 0);
    chk("rst_wrap_pulse", wrap_pulse, 0);
    chk("rst_rollover_flag_r0", rollover_flag, 1);
    rollover_val = 4'd5; count_down = 1'b1;
    #1;
    chk("rst_rollover_flag_r5", rollover_flag, 0);
    chk("rst_terminal_down", terminal_flag, 1);
    count_down = 1'b0;
    #1;
    chk("rst_terminal_up", terminal_flag, 0);

    // Up / wrap, R=5, 12 enables
    count_enable = 1'b1;
    #7 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("up_wrap_count[%0d]", i), count_out, exp_up[i]);
      pulses += int'(wrap_pulse);
    end
    count_enable = 1'b0;
    chk("up_wrap_pulses", pulses, 2);
    chk("up_wrap_wrap_count", wrap_count, 2);
    step();
    chk("idle_hold_count", count_out, 2);
    chk("idle_pulse_low", wrap_pulse, 0);

    // Down / wrap, load 3, R=4, 5 enables
    do_clear();
    load = 1'b1; load_val = 4'd3; rollover_val = 4'd4;
    step();
    chk("load_count", count_out, 3);
    chk("load_pulse", wrap_pulse, 0);
    load = 1'b0; count_down = 1'b1; count_enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("down_wrap_count[%0d]", i), count_out, exp_dn[i]);
      pulses += int'(wrap_pulse);
    end
    count_enable = 1'b0;
    chk("down_wrap_pulses", pulses, 1);
    chk("down_wrap_wrap_count", wrap_count, 1);

    // Saturate, R=7, up, 10 enables
    do_clear();
    rollover_val = 4'd7; sat_mode = 1'b1; count_down = 1'b0; count_enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("sat_count[%0d]", i), count_out, (i + 1 > 7) ? 7 : i + 1);
      pulses += int'(wrap_pulse);
    end
    chk("sat_terminal", terminal_flag, 1);
    chk("sat_rollover_flag", rollover_flag, 1);
    chk("sat_pulses", pulses, 0);
    chk("sat_wrap_count", wrap_count, 0);

    // Priority: one wrap first so the clear has a tally to zero
    sat_mode = 1'b0;
    step();
    chk("prio_prewrap_count", count_out, 1);
    chk("prio_prewrap_wrap_count", wrap_count, 1);
    count_enable = 1'b0; load = 1'b1; load_val = 4'd6;
    step();
    chk("prio_load6", count_out, 6);
    chk("prio_load_keeps_wrap_count", wrap_count, 1);
    clear = 1'b1; load = 1'b1; load_val = 4'd9; count_enable = 1'b1;
    step();
    chk("prio_clear_count", count_out, 0);
    chk("prio_clear_wrap_count", wrap_count, 0);
    clear = 1'b0; load = 1'b0; count_enable = 1'b0;

    // Wrap tally saturation on the 2-bit instance, R=2, 20 enables
    do_clear();
    rollover_val = 4'd2; count_down = 1'b0; count_enable = 1'b1;
    pulses2 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      pulses2 += int'(wrap_pulse2);
      if (i == 18) chk("wsat_pulse_after_sat", wrap_pulse2, 1);
    end
    count_enable = 1'b0;
    chk("wsat_wrap_count2", wrap_count2, 3);
    chk("wsat_pulses2", pulses2, 9);
    chk("wsat_wrap_count8", wrap_count, 9);
    chk("wsat_count", count_out2, 2);

    // Load above R, next up step wraps to 1
    load = 1'b1; load_val = 4'd9; rollover_val = 4'd5;
    step();
    load = 1'b0; count_enable = 1'b1;
    step();
    chk("over_r_count", count_out, 1);
    chk("over_r_pulse", wrap_pulse, 1);

    // R = 0 up: 0 -> 1 -> 1, pulsing each step
    do_clear();
    rollover_val = 4'd0; count_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("r0_up_count[%0d]", i), count_out, 1);
      chk($sformatf("r0_up_pulse[%0d]", i), wrap_pulse, 1);
    end
    // R = 0 down: terminal step loads 0
    count_down = 1'b1;
    step();
    chk("r0_down_count", count_out, 0);
    chk("r0_down_pulse", wrap_pulse, 1);
    chk("r0_down_wrap_count", wrap_count, 4);

    // Async reset between edges at count 4
    count_down = 1'b0; count_enable = 1'b0; rollover_val = 4'd5;
    load = 1'b1; load_val = 4'd4;
    step();
    load = 1'b0;
    chk("areset_pre_count", count_out, 4);
    count_enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", count_out, 0);
    chk("areset_wrap_count", wrap_count, 0);
    #1 rst_n = 1'b1;
    step();
    chk("areset_first_step", count_out, 1);
    count_enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
